if_id_stage_mod: RTL and testbench

//  Fetch-side stage of the pipelined RISC: program counter, instruction-memory address,
//  and IF/ID pipeline register with stall and flush. Slices the latched instruction

---
 rtl/if_id_stage_mod_if.sv | 21 ++
 rtl/if_id_stage_mod.sv | 126 ++++++++++++
 tb/tb_if_id_stage_mod.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/if_id_stage_mod_if.sv
// -----------------------------------------------------------------------------
// if_id_stage_mod_if
//   Instruction-memory bus between the fetch stage and the instruction memory.
//   The memory read is combinational: imem_data_i reflects imem_addr_o in the
//   same cycle.
//
//   Signals (names are relative to the fetch stage):
//     imem_addr_o  [31:0]  fetch address, driven by the stage (current PC)
//     imem_data_i  [31:0]  instruction word, driven by the memory
//
//   Modports:
//     master  - fetch stage (drives address, receives data)
//     slave   - instruction memory (receives address, drives data)
// -----------------------------------------------------------------------------
interface if_id_stage_mod_if;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_data_i;

    modport master (output imem_addr_o, input  imem_data_i);
    modport slave  (input  imem_addr_o, output imem_data_i);
endinterface : if_id_stage_mod_if

// File: rtl/if_id_stage_mod.sv
// -----------------------------------------------------------------------------
// if_id_stage_mod
//   Fetch side of the pipelined RISC: program counter, instruction-memory
//   address and the IF/ID pipeline register with stall and flush. The latched
//   instruction is sliced into the fields the ID stage needs.
//
//   Instruction format: opcode[31:27] Ra[26:22] Rb[21:17] imm[16:5] Rc[4:0]
//
//   Parameters:
//     RESET_PC   PC loaded on reset (bits [1:0] must be 0)
//     LONG_OPC   opcode selecting the 17-bit imm+Rc immediate form
//     NOP_INSTR  instruction word held in IF/ID after reset or flush
//
//   Ports:
//     clk_i        in   clock, rising edge
//     rst_ni       in   asynchronous active-low reset
//     stall_i      in   hold PC and IF/ID
//     redirect_i   in   taken branch/jump; load target_i and flush IF/ID
//     target_i     in   redirect target (low two bits ignored)
//     imem         if   instruction-memory bus (master)
//     valid_o      out  IF/ID holds a real instruction
//     pc_o         out  PC of the instruction in IF/ID
//     instr_o      out  latched instruction word
//     opcode_o / ra_o / rb_o / imm_o / rc_o  out  field slices of instr_o
//     ext_ctrl_o   out  1 when a valid LONG_OPC instruction is in IF/ID
//
//   Optional feature (macro PERF_CNT_EN):
//     stall_cnt_o  out  saturating count of cycles with stall_i=1, redirect_i=0
//     flush_cnt_o  out  saturating count of cycles with redirect_i=1
// -----------------------------------------------------------------------------
module if_id_stage_mod #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [4:0]  LONG_OPC  = 5'b10110,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                stall_i,
    input  logic                redirect_i,
    input  logic [31:0]         target_i,
    if_id_stage_mod_if.master   imem,
    output logic                valid_o,
    output logic [31:0]         pc_o,
    output logic [31:0]         instr_o,
    output logic [4:0]          opcode_o,
    output logic [4:0]          ra_o,
    output logic [4:0]          rb_o,
    output logic [11:0]         imm_o,
    output logic [4:0]          rc_o,
    output logic                ext_ctrl_o
`ifdef PERF_CNT_EN
    ,
    output logic [31:0]         stall_cnt_o,
    output logic [31:0]         flush_cnt_o
`endif
);

    logic [31:0] r_pc;
    logic        r_valid;
    logic [31:0] r_id_pc;
    logic [31:0] r_instr;
    logic [31:0] w_target_aligned;

    // Masking (rather than slicing) keeps every target bit consumed while
    // dropping the misaligned low bits.
    assign w_target_aligned = target_i & ~32'h0000_0003;

    // Priority: reset > redirect > stall > advance. PC + 4 wraps modulo 2^32.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours (pc_id gets the old PC).
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pc    <= RESET_PC;
            r_valid <= 1'b0;
            r_id_pc <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (redirect_i) begin
            r_pc    <= w_target_aligned;
            r_valid <= 1'b0;
            r_id_pc <= 32'h0000_0000;
            r_instr <= NOP_INSTR;
        end else if (!stall_i) begin
            r_pc    <= r_pc + 32'd4;
            r_valid <= 1'b1;
            r_id_pc <= r_pc;
            r_instr <= imem.imem_data_i;
        end
    end

    // The fetch address is the PC register itself: no combinational path
    // from stall_i or redirect_i reaches the memory.
    assign imem.imem_addr_o = r_pc;

    assign valid_o    = r_valid;
    assign pc_o       = r_id_pc;
    assign instr_o    = r_instr;
    assign opcode_o   = r_instr[31:27];
    assign ra_o       = r_instr[26:22];
    assign rb_o       = r_instr[21:17];
    assign imm_o      = r_instr[16:5];
    assign rc_o       = r_instr[4:0];
    // Bubbles always select the short immediate form.
    assign ext_ctrl_o = r_valid && (r_instr[31:27] == LONG_OPC);

`ifdef PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    // A stall that coincides with a redirect is counted only as a flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_stall_cnt <= 32'h0000_0000;
            r_flush_cnt <= 32'h0000_0000;
        end else begin
            if (stall_i && !redirect_i && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if (redirect_i && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`endif

endmodule : if_id_stage_mod

// File: tb/tb_if_id_stage_mod.sv
// -----------------------------------------------------------------------------
// tb_if_id_stage_mod
//   Self-checking bench for if_id_stage_mod: directed scenarios followed by
//   randomized stall/redirect traffic, compared against a transaction-level
//   model of the fetch stage (PC, IF/ID contents, event counts).
// -----------------------------------------------------------------------------
module tb_if_id_stage_mod;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [4:0]  LONG_OPC  = 5'b10110;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] WORD0     = 32'hB0A4_C3E7;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        stall_i;
    logic        redirect_i;
    logic [31:0] target_i;
    logic        valid_o;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic [4:0]  opcode_o;
    logic [4:0]  ra_o;
    logic [4:0]  rb_o;
    logic [11:0] imm_o;
    logic [4:0]  rc_o;
    logic        ext_ctrl_o;
`ifdef PERF_CNT_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] seed;

    if_id_stage_mod_if bus ();

    // Instruction memory: address 0 holds the directed word, every other
    // address a seed-dependent scramble so each fetch is distinguishable.
    function automatic logic [31:0] imem_word(input logic [31:0] a, input logic [31:0] s);
        if (a == 32'h0) return WORD0;
        return (a * 32'h9E37_79B1) ^ s;
    endfunction

    assign bus.imem_data_i = imem_word(bus.imem_addr_o, seed);

    if_id_stage_mod #(
        .RESET_PC (RESET_PC),
        .LONG_OPC (LONG_OPC),
        .NOP_INSTR(NOP_INSTR)
    ) dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .stall_i    (stall_i),
        .redirect_i (redirect_i),
        .target_i   (target_i),
        .imem       (bus.master),
        .valid_o    (valid_o),
        .pc_o       (pc_o),
        .instr_o    (instr_o),
        .opcode_o   (opcode_o),
        .ra_o       (ra_o),
        .rb_o       (rb_o),
        .imm_o      (imm_o),
        .rc_o       (rc_o),
        .ext_ctrl_o (ext_ctrl_o)
`ifdef PERF_CNT_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    logic [31:0] m_fetch_pc;   // address being fetched
    logic        m_valid;      // IF/ID occupancy
    logic [31:0] m_id_pc;
    logic [31:0] m_instr;
    longint      m_stalls;
    longint      m_flushes;

    task automatic model_reset();
        m_fetch_pc = RESET_PC;
        m_valid    = 1'b0;
        m_id_pc    = 32'h0;
        m_instr    = NOP_INSTR;
        m_stalls   = 0;
        m_flushes  = 0;
    endtask

    task automatic model_clock(input logic s, input logic r, input logic [31:0] t);
        if (r) begin
            m_fetch_pc = t - (t % 4);
            m_valid    = 1'b0;
            m_id_pc    = 32'h0;
            m_instr    = NOP_INSTR;
            m_flushes++;
        end else if (s) begin
            m_stalls++;
        end else begin
            m_valid    = 1'b1;
            m_id_pc    = m_fetch_pc;
            m_instr    = imem_word(m_fetch_pc, seed);
            m_fetch_pc = 32'((64'(m_fetch_pc) + 64'd4) % 64'h1_0000_0000);
        end
    endtask

    function automatic logic [31:0] sat32(input longint n);
        return (n > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : 32'(n);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        logic [31:0] w;
        w = m_instr;
        check({ctx, " imem_addr"}, bus.imem_addr_o, m_fetch_pc);
        check({ctx, " valid"},     32'(valid_o),    32'(m_valid));
        check({ctx, " pc"},        pc_o,            m_id_pc);
        check({ctx, " instr"},     instr_o,         w);
        check({ctx, " opcode"},    32'(opcode_o),   w / 32'h0800_0000);
        check({ctx, " ra"},        32'(ra_o),       (w / 32'h0040_0000) % 32);
        check({ctx, " rb"},        32'(rb_o),       (w / 32'h0002_0000) % 32);
        check({ctx, " imm"},       32'(imm_o),      (w / 32) % 4096);
        check({ctx, " rc"},        32'(rc_o),       w % 32);
        check({ctx, " ext_ctrl"},  32'(ext_ctrl_o),
              32'(m_valid && ((w / 32'h0800_0000) == 32'(LONG_OPC))));
`ifdef PERF_CNT_EN
        check({ctx, " stall_cnt"}, stall_cnt_o, sat32(m_stalls));
        check({ctx, " flush_cnt"}, flush_cnt_o, sat32(m_flushes));
`endif
    endtask

    // One clock with the given controls, then compare one time unit later.
    task automatic cycle(input string ctx, input logic s, input logic r, input logic [31:0] t);
        stall_i    = s;
        redirect_i = r;
        target_i   = t;
        @(posedge clk_i);
        model_clock(s, r, t);
        #1;
        check_all(ctx);
    endtask

    initial begin
        seed       = $urandom;
        rst_ni     = 1'b0;
        stall_i    = 1'b0;
        redirect_i = 1'b0;
        target_i   = 32'h0;
        model_reset();
        #12;
        rst_ni = 1'b1;
        #1;
        check_all("reset");

        // 1. first fetch from RESET_PC
        cycle("first", 1'b0, 1'b0, 32'h0);
        check("first valid",    32'(valid_o),    32'd1);
        check("first pc",       pc_o,            32'h0);
        check("first opcode",   32'(opcode_o),   32'(5'b10110));
        check("first ext_ctrl", 32'(ext_ctrl_o), 32'd1);
        check("first imm",      32'(imm_o),      (WORD0 / 32) % 4096);
        check("first rc",       32'(rc_o),       32'h07);
        check("first addr",     bus.imem_addr_o, 32'h4);

        // 2. three stall cycles at PC=8, then advance
        cycle("adv8", 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            cycle("stall", 1'b1, 1'b0, 32'h0);
            check("stall addr",  bus.imem_addr_o, 32'h8);
            check("stall instr", instr_o,         imem_word(32'h4, seed));
        end
        cycle("post_stall", 1'b0, 1'b0, 32'h0);
        check("post_stall pc",   pc_o,            32'h8);
        check("post_stall addr", bus.imem_addr_o, 32'hC);

        // 3. redirect overrides a simultaneous stall; low target bits dropped
        cycle("redirect", 1'b1, 1'b1, 32'h0000_0103);
        check("redirect addr",  bus.imem_addr_o, 32'h100);
        check("redirect valid", 32'(valid_o),    32'd0);
        check("redirect instr", instr_o,         NOP_INSTR);
        check("redirect ext",   32'(ext_ctrl_o), 32'd0);

        // 4. PC wrap
        cycle("to_top", 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle("wrap", 1'b0, 1'b0, 32'h0);
        check("wrap addr", bus.imem_addr_o, 32'h0);
        check("wrap pc",   pc_o,            32'hFFFF_FFFC);

        // 6. five stall cycles total, two redirects (one with stall)
        cycle("stall5", 1'b1, 1'b0, 32'h0);
`ifdef PERF_CNT_EN
        check("perf stall_cnt", stall_cnt_o, 32'd4);
        check("perf flush_cnt", flush_cnt_o, 32'd2);
`endif

        // 5. asynchronous reset while IF/ID is valid
        cycle("pre_reset", 1'b0, 1'b0, 32'h0);
        check("pre_reset valid", 32'(valid_o), 32'd1);
        #3;
        rst_ni = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset valid", 32'(valid_o), 32'd0);
        #2;
        rst_ni = 1'b1;
        cycle("restart", 1'b0, 1'b0, 32'h0);
        check("restart pc",   pc_o,            RESET_PC);
        check("restart addr", bus.imem_addr_o, RESET_PC + 32'd4);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic s, r;
            s = ($urandom_range(0, 99) < 30);
            r = ($urandom_range(0, 99) < 10);
            cycle("random", s, r, $urandom);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_if_id_stage_mod
